mips_multicycle_ctrl: RTL and testbench

- Multicycle control FSM for the 16-bit mini MIPS. It sequences one shared ALU, the register file, the PC/IR and a single unified memory port with a ready handshake.
- Decodes the 4-bit opcode into per-state control strobes and drives the 3-bit ALUOp consumed by ALUControl.
- Also keeps a retired-instruction counter and a memory-wait watchdog.

---
 rtl/mips_multicycle_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control FSM for the 16-bit mini MIPS: sequences ALU, register file,
// PC/IR and the shared memory port, with retired-instruction count and memory watchdog.
module mips_multicycle_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             instr_done,
    output logic             illegal_op,
    output logic             bus_error,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    // state    | meaning
    // ---------+----------------------------------------------
    // FETCH    | read instruction at PC, load IR, PC += 2
    // DECODE   | dispatch on opcode, flag illegal opcodes
    // EXEC_R   | ALU on rs, rt with funct-controlled operation
    // EXEC_I   | ALU on rs and extended immediate
    // ALU_WB   | write ALUOut back to rd / rt
    // MEM_ADDR | compute rs + sign-extended offset
    // MEM_RD   | load data read, waits for mem_ready
    // MEM_WB   | write MDR back to rt
    // MEM_WR   | store data write, waits for mem_ready
    // BRANCH   | compare rs/rt, conditionally load branch target
    // JUMP     | load jump target
    // HALT     | terminal until reset
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_ANDI = 4'b0010;
    localparam logic [3:0] OP_ORI  = 4'b0011;
    localparam logic [3:0] OP_SLTI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SW   = 4'b0110;
    localparam logic [3:0] OP_BEQ  = 4'b0111;
    localparam logic [3:0] OP_BNE  = 4'b1000;
    localparam logic [3:0] OP_J    = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_state;
    logic              wd_expire;
    logic              set_illegal;

    assign mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // Expiry fires on the MAX_WAIT-th consecutive stalled cycle.
    assign wd_expire = mem_state && !mem_ready && (wait_cnt == WAIT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            wait_cnt   <= '0;
            illegal_op <= 1'b0;
            bus_error  <= 1'b0;
            retired    <= '0;
        end else begin
            state <= state_next;
            if (mem_state && !mem_ready && !wd_expire)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            else
                wait_cnt <= '0;
            if (wd_expire)
                bus_error <= 1'b1;
            if (set_illegal)
                illegal_op <= 1'b1;
            if (instr_done && !set_illegal)
                retired <= retired + CNT_W'(1);
        end
    end

    // Outputs are held at zero while reset is asserted, so an aborted access drops at once.
    always_comb begin
        state_next  = state;
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        ir_write    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        i_or_d      = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 3'b000;
        instr_done  = 1'b0;
        halted      = 1'b0;
        set_illegal = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_read = 1'b1;
                    if (wd_expire) begin
                        state_next = S_HALT;
                    end else if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        state_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_R:                             state_next = S_EXEC_R;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = S_EXEC_I;
                        OP_LW, OP_SW:                     state_next = S_MEM_ADDR;
                        OP_BEQ, OP_BNE:                   state_next = S_BRANCH;
                        OP_J:                             state_next = S_JUMP;
                        OP_HALT:                          state_next = S_HALT;
                        default: begin
                            set_illegal = 1'b1;
                            instr_done  = 1'b1;
                            state_next  = S_FETCH;
                        end
                    endcase
                end
                S_EXEC_R: begin
                    alu_src_a  = 1'b1;
                    alu_op     = 3'b111;
                    state_next = S_ALU_WB;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    case (opcode)
                        OP_ANDI: begin alu_src_b = 2'b10; alu_op = 3'b100; end
                        OP_ORI:  begin alu_src_b = 2'b10; alu_op = 3'b101; end
                        OP_SLTI: begin alu_src_b = 2'b01; alu_op = 3'b110; end
                        default: begin alu_src_b = 2'b01; alu_op = 3'b000; end
                    endcase
                    state_next = S_ALU_WB;
                end
                S_ALU_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = (opcode == OP_R);
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end
                S_MEM_ADDR: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b01;
                    state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    if (wd_expire)
                        state_next = S_HALT;
                    else if (mem_ready)
                        state_next = S_MEM_WB;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    if (wd_expire) begin
                        state_next = S_HALT;
                    end else if (mem_ready) begin
                        instr_done = 1'b1;
                        state_next = S_FETCH;
                    end
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = 3'b001;
                    pc_src     = 2'b01;
                    pc_write   = (opcode == OP_BNE) ? !zero : zero;
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end
                S_JUMP: begin
                    pc_src     = 2'b10;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: state_next = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class, the watchdog,
// counter wrap and asynchronous reset, checking the control word cycle by cycle.
module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
    logic       bus_error;
    logic       halted;
    logic [3:0] retired;

    int checks   = 0;
    int failures = 0;

    mips_multicycle_ctrl #(.MAX_WAIT(15), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .bus_error  (bus_error),
        .halted     (halted),
        .retired    (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [17:0] ctrl;
    assign ctrl = {pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d, reg_write,
                   reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, instr_done, halted};

    function automatic logic [17:0] cv(input logic pcw, input logic [1:0] pcs,
                                       input logic irw, input logic mr, input logic mw,
                                       input logic iod, input logic rw, input logic rd,
                                       input logic m2r, input logic asa,
                                       input logic [1:0] asb, input logic [2:0] aop,
                                       input logic done, input logic hlt);
        return {pcw, pcs, irw, mr, mw, iod, rw, rd, m2r, asa, asb, aop, done, hlt};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [17:0] e_zero, e_fwait, e_frdy, e_exr, e_wbr, e_wbi, e_addi, e_andi, e_ori, e_slti;
    logic [17:0] e_maddr, e_mrd, e_mwb, e_mwrw, e_mwrr, e_brt, e_brn, e_jmp, e_halt, e_ill;

    initial begin
        e_zero  = '0;
        e_fwait = cv(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0);
        e_frdy  = cv(1, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0);
        e_exr   = cv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b111, 0, 0);
        e_wbr   = cv(0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 3'b000, 1, 0);
        e_wbi   = cv(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 3'b000, 1, 0);
        e_addi  = cv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 3'b000, 0, 0);
        e_andi  = cv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b100, 0, 0);
        e_ori   = cv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b101, 0, 0);
        e_slti  = cv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 3'b110, 0, 0);
        e_maddr = cv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 3'b000, 0, 0);
        e_mrd   = cv(0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0);
        e_mwb   = cv(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 1, 0);
        e_mwrw  = cv(0, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0);
        e_mwrr  = cv(0, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 3'b000, 1, 0);
        e_brt   = cv(1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 1, 0);
        e_brn   = cv(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 1, 0);
        e_jmp   = cv(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1, 0);
        e_halt  = cv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 1);
        e_ill   = cv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1, 0);

        rst_n = 1'b0; opcode = 4'b0000; zero = 1'b0; mem_ready = 1'b1;
        #1;
        chk("reset_ctrl", 32'(ctrl), 32'(e_zero));
        chk("reset_retired", 32'(retired), 0);
        chk("reset_flags", 32'({illegal_op, bus_error, halted}), 0);

        // R-type
        @(negedge clk); rst_n = 1'b1; #1;
        chk("r_fetch", 32'(ctrl), 32'(e_frdy));
        cyc(); chk("r_decode", 32'(ctrl), 32'(e_zero));
        cyc(); chk("r_exec", 32'(ctrl), 32'(e_exr));
        cyc(); chk("r_wb", 32'(ctrl), 32'(e_wbr));
        chk("r_retired_before", 32'(retired), 0);
        cyc(); chk("r_retired_after", 32'(retired), 1);
        chk("r_back_fetch", 32'(ctrl), 32'(e_frdy));

        // I-type variants
        opcode = 4'b0001; cyc(); cyc(); chk("addi_exec", 32'(ctrl), 32'(e_addi));
        cyc(); chk("addi_wb", 32'(ctrl), 32'(e_wbi));
        cyc();
        opcode = 4'b0010; cyc(); cyc(); chk("andi_exec", 32'(ctrl), 32'(e_andi));
        cyc(); cyc();
        opcode = 4'b0011; cyc(); cyc(); chk("ori_exec", 32'(ctrl), 32'(e_ori));
        cyc(); cyc();
        opcode = 4'b0100; cyc(); cyc(); chk("slti_exec", 32'(ctrl), 32'(e_slti));
        cyc(); cyc();
        chk("itype_retired", 32'(retired), 5);

        // lw with 3 stall cycles in MEM_RD
        opcode = 4'b0101; cyc(); cyc();
        chk("lw_addr", 32'(ctrl), 32'(e_maddr));
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); chk("lw_rd_wait", 32'(ctrl), 32'(e_mrd));
        end
        mem_ready = 1'b1; #1;
        chk("lw_rd_ready", 32'(ctrl), 32'(e_mrd));
        cyc(); chk("lw_wb", 32'(ctrl), 32'(e_mwb));
        cyc(); chk("lw_retired", 32'(retired), 6);

        // sw with one stall cycle in MEM_WR
        opcode = 4'b0110; cyc(); cyc(); mem_ready = 1'b0;
        cyc(); chk("sw_wr_wait", 32'(ctrl), 32'(e_mwrw));
        mem_ready = 1'b1; #1;
        chk("sw_wr_ready", 32'(ctrl), 32'(e_mwrr));
        cyc(); chk("sw_retired", 32'(retired), 7);

        // beq taken, beq not taken, bne taken
        opcode = 4'b0111; zero = 1'b1; cyc(); cyc();
        chk("beq_taken", 32'(ctrl), 32'(e_brt));
        cyc(); zero = 1'b0; cyc(); cyc();
        chk("beq_not_taken", 32'(ctrl), 32'(e_brn));
        cyc();
        opcode = 4'b1000; cyc(); cyc();
        chk("bne_taken", 32'(ctrl), 32'(e_brt));
        zero = 1'b1; #1;
        chk("bne_not_taken", 32'(ctrl), 32'(e_brn));
        zero = 1'b0;
        cyc(); chk("branch_retired", 32'(retired), 10);

        // jump
        opcode = 4'b1001; cyc(); cyc();
        chk("j_exec", 32'(ctrl), 32'(e_jmp));
        cyc(); chk("j_retired", 32'(retired), 11);

        // illegal opcode
        opcode = 4'b1010; cyc();
        chk("ill_decode", 32'(ctrl), 32'(e_ill));
        chk("ill_not_yet", 32'(illegal_op), 0);
        cyc(); chk("ill_set", 32'(illegal_op), 1);
        chk("ill_retired", 32'(retired), 11);
        chk("ill_fetch", 32'(ctrl), 32'(e_frdy));
        opcode = 4'b1001; cyc(); cyc(); cyc();
        chk("ill_sticky", 32'(illegal_op), 1);

        // halt
        opcode = 4'b1111; cyc();
        chk("halt_decode", 32'(ctrl), 32'(e_zero));
        cyc();
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            zero      = 1'($urandom_range(0, 1));
            #1; chk("halt_hold", 32'(ctrl), 32'(e_halt));
            cyc();
        end
        chk("halt_retired", 32'(retired), 12);

        // reset pulse, then retired wrap via jumps
        rst_n = 1'b0; #1;
        chk("rst2_flags", 32'({illegal_op, bus_error, halted}), 0);
        chk("rst2_retired", 32'(retired), 0);
        mem_ready = 1'b1; zero = 1'b0; opcode = 4'b1001;
        @(negedge clk); rst_n = 1'b1; #1;
        for (int i = 0; i < 15; i++) begin
            cyc(); cyc(); cyc();
        end
        chk("wrap_15", 32'(retired), 15);
        cyc(); cyc(); cyc();
        chk("wrap_0", 32'(retired), 0);
        cyc(); cyc(); cyc();
        chk("wrap_1", 32'(retired), 1);

        // watchdog in FETCH
        mem_ready = 1'b0; #1;
        chk("wd_fetch_wait", 32'(ctrl), 32'(e_fwait));
        for (int i = 0; i < 14; i++) cyc();
        chk("wd_edge14_ctrl", 32'(ctrl), 32'(e_fwait));
        chk("wd_edge14_err", 32'(bus_error), 0);
        cyc();
        chk("wd_halt", 32'(ctrl), 32'(e_halt));
        chk("wd_err", 32'(bus_error), 1);
        chk("wd_retired", 32'(retired), 1);

        rst_n = 1'b0; #1;
        chk("rst3_err", 32'(bus_error), 0);
        chk("rst3_ctrl", 32'(ctrl), 32'(e_zero));
        chk("rst3_retired", 32'(retired), 0);
        mem_ready = 1'b1; opcode = 4'b0110;
        @(negedge clk); rst_n = 1'b1; #1;
        chk("rst3_fetch", 32'(ctrl), 32'(e_frdy));

        // reset during MEM_WR stall
        cyc(); cyc(); mem_ready = 1'b0;
        cyc(); chk("swr_wait1", 32'(ctrl), 32'(e_mwrw));
        cyc(); chk("swr_wait2", 32'(ctrl), 32'(e_mwrw));
        #2; rst_n = 1'b0; #1;
        chk("swr_abort_ctrl", 32'(ctrl), 32'(e_zero));
        chk("swr_abort_flags", 32'({illegal_op, bus_error, halted, retired}), 0);
        @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1; #1;
        chk("swr_restart", 32'(ctrl), 32'(e_frdy));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
